// File: rtl/matrix_io_sequencer_if.sv
// rtl/matrix_io_sequencer_if.sv - operand load, multiply handshake and result stream bundle
interface matrix_io_sequencer_if;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic [15:0] matrixA;
  logic [15:0] matrixB;
  logic        enable;
  logic        listo;
  logic [15:0] result;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err;

  // sequencer side
  modport master (
    input  data_in, data_valid, listo, result, out_ready,
    output data_ready, matrixA, matrixB, enable, data_out, out_valid, busy, err
  );

  // environment side: byte source, multiply unit and result consumer
  modport slave (
    output data_in, data_valid, listo, result, out_ready,
    input  data_ready, matrixA, matrixB, enable, data_out, out_valid, busy, err
  );
endinterface

// File: rtl/matrix_io_sequencer.sv
// rtl/matrix_io_sequencer.sv - loads two 16-bit operands, starts the multiply unit, streams the product out
module matrix_io_sequencer #(
  parameter int TIMEOUT_CYCLES = 127
) (
  input logic                   clk,
  input logic                   rst,
  matrix_io_sequencer_if.master bus
);

  typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

  // Last timeout count value; the edge leaving it aborts the wait.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        idx_q, idx_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] mat_a_q, mat_a_d;
  logic [15:0] mat_b_q, mat_b_d;
  logic        enable_q, enable_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        data_ready_q, data_ready_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = bus.data_valid & data_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  // State register and all registered outputs; reset discards any partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      byte_cnt_q   <= 2'd0;
      tmo_q        <= 8'd0;
      idx_q        <= 1'b0;
      cap_q        <= 16'd0;
      mat_a_q      <= 16'd0;
      mat_b_q      <= 16'd0;
      enable_q     <= 1'b0;
      data_out_q   <= 8'd0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_q        <= tmo_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      enable_q     <= enable_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      data_ready_q <= data_ready_d;
    end
  end

  // Next-state logic; status outputs are derived from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmo_d      = tmo_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;
    data_out_d = data_out_q;
    err_d      = err_q;

    case (state_q)
      LOAD: begin
        if (in_xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: begin
              mat_a_d[7:0] = bus.data_in;
              err_d        = 1'b0;
            end
            2'd1: mat_a_d[15:8] = bus.data_in;
            2'd2: mat_b_d[7:0]  = bus.data_in;
            2'd3: begin
              mat_b_d[15:8] = bus.data_in;
              state_d       = START;
            end
          endcase
        end
      end
      START: begin
        tmo_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over a coinciding timeout.
        if (bus.listo) begin
          cap_d      = bus.result;
          idx_d      = 1'b0;
          data_out_d = bus.result[7:0];
          state_d    = SEND;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = LOAD;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (!idx_q) begin
            idx_d      = 1'b1;
            data_out_d = cap_q[15:8];
          end else begin
            state_d = LOAD;
          end
        end
      end
    endcase

    enable_d     = (state_d == START);
    out_valid_d  = (state_d == SEND);
    busy_d       = (state_d != LOAD);
    data_ready_d = (state_d == LOAD);
  end

  assign bus.data_ready = data_ready_q;
  assign bus.matrixA    = mat_a_q;
  assign bus.matrixB    = mat_b_q;
  assign bus.enable     = enable_q;
  assign bus.data_out   = data_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// tb/tb_matrix_io_sequencer.sv - randomized bench with a transaction-level reference model
module tb_matrix_io_sequencer;
  localparam int T = 127;

  logic clk = 1'b0;
  logic rst = 1'b0;

  matrix_io_sequencer_if bus();

  matrix_io_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: operand registers as assembled from accepted bytes, sticky error.
  logic [15:0] ma_exp;
  logic [15:0] mb_exp;
  logic        err_exp;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.data_in    = 8'd0;
    bus.data_valid = 1'b0;
    bus.listo      = 1'b0;
    bus.result     = 16'd0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic check_held(input string phase);
    check_eq({phase, "_matrixA"}, bus.matrixA, ma_exp);
    check_eq({phase, "_matrixB"}, bus.matrixB, mb_exp);
    check_eq({phase, "_err"}, 16'(bus.err), 16'(err_exp));
  endtask

  task automatic reset_dut;
    idle_inputs();
    rst = 1'b1;
    #1;
    ma_exp  = 16'd0;
    mb_exp  = 16'd0;
    err_exp = 1'b0;
    check_held("rst");
    check_eq("rst_enable", 16'(bus.enable), 16'd0);
    check_eq("rst_data_out", 16'(bus.data_out), 16'd0);
    check_eq("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check_eq("rst_busy", 16'(bus.busy), 16'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_data_ready", 16'(bus.data_ready), 16'd1);
  endtask

  // Offers bytes w[7:0], w[15:8], ... with random gaps and stray listo pulses.
  task automatic load_bytes(input logic [31:0] w, input int n, input int gap_pct, input int stray_pct);
    int acc = 0;
    int it  = 0;
    logic v;
    logic [7:0] b;
    while (acc < n && it < 200) begin
      b = w[8*acc +: 8];
      v = (int'($urandom_range(99)) >= gap_pct);
      bus.data_valid = v;
      bus.data_in    = v ? b : 8'($urandom);
      bus.listo      = (int'($urandom_range(99)) < stray_pct);
      bus.result     = 16'($urandom);
      check_eq("load_data_ready", 16'(bus.data_ready), 16'd1);
      check_eq("load_enable", 16'(bus.enable), 16'd0);
      check_eq("load_busy", 16'(bus.busy), 16'd0);
      check_eq("load_out_valid", 16'(bus.out_valid), 16'd0);
      check_held("load");
      tick();
      if (v) begin
        case (acc)
          0: begin ma_exp[7:0] = b; err_exp = 1'b0; end
          1: ma_exp[15:8] = b;
          2: mb_exp[7:0]  = b;
          default: mb_exp[15:8] = b;
        endcase
        acc++;
      end
      it++;
    end
    bus.data_valid = 1'b0;
    bus.listo      = 1'b0;
    if (acc < n) check_eq("load_bound", 16'(acc), 16'(n));
    if (n == 4) begin
      check_eq("start_enable", 16'(bus.enable), 16'd1);
      check_eq("start_busy", 16'(bus.busy), 16'd1);
      check_eq("start_data_ready", 16'(bus.data_ready), 16'd0);
      check_eq("start_out_valid", 16'(bus.out_valid), 16'd0);
      check_held("start");
    end
  endtask

  task automatic send_byte(input logic [7:0] exp, input int stall, input string tag);
    for (int k = 0; k <= stall; k++) begin
      bus.out_ready = (k == stall);
      bus.listo     = ($urandom_range(3) == 0);
      bus.result    = 16'($urandom);
      check_eq({tag, "_out_valid"}, 16'(bus.out_valid), 16'd1);
      check_eq({tag, "_data_out"}, 16'(bus.data_out), 16'(exp));
      check_eq({tag, "_busy"}, 16'(bus.busy), 16'd1);
      check_eq({tag, "_data_ready"}, 16'(bus.data_ready), 16'd0);
      tick();
    end
    bus.listo     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Called in the enable cycle; pulses listo lat cycles later (1 <= lat <= T).
  task automatic respond(input int lat, input logic [15:0] r, input int s0, input int s1, input bit abort);
    for (int k = 1; k <= lat; k++) begin
      tick();
      bus.listo = 1'b0;
      check_eq("wait_enable", 16'(bus.enable), 16'd0);
      check_eq("wait_out_valid", 16'(bus.out_valid), 16'd0);
      check_eq("wait_busy", 16'(bus.busy), 16'd1);
      check_eq("wait_data_ready", 16'(bus.data_ready), 16'd0);
      check_held("wait");
      if (k == lat) begin
        bus.listo  = 1'b1;
        bus.result = r;
      end
    end
    tick();
    bus.listo  = 1'b0;
    bus.result = 16'($urandom);
    if (abort) begin
      check_eq("abort_out_valid", 16'(bus.out_valid), 16'd1);
      tick();
      reset_dut();
      check_eq("abort_no_output", 16'(bus.out_valid), 16'd0);
    end else begin
      send_byte(r[7:0], s0, "send0");
      send_byte(r[15:8], s1, "send1");
      check_eq("done_out_valid", 16'(bus.out_valid), 16'd0);
      check_eq("done_data_ready", 16'(bus.data_ready), 16'd1);
      check_eq("done_busy", 16'(bus.busy), 16'd0);
      check_held("done");
    end
  endtask

  // Called in the enable cycle; listo never arrives.
  task automatic timeout_run;
    for (int k = 1; k <= T; k++) begin
      tick();
      check_eq("to_wait_out_valid", 16'(bus.out_valid), 16'd0);
      check_eq("to_wait_busy", 16'(bus.busy), 16'd1);
      check_eq("to_wait_enable", 16'(bus.enable), 16'd0);
      check_held("to_wait");
    end
    tick();
    err_exp = 1'b1;
    check_held("to_done");
    check_eq("to_out_valid", 16'(bus.out_valid), 16'd0);
    check_eq("to_data_ready", 16'(bus.data_ready), 16'd1);
    check_eq("to_busy", 16'(bus.busy), 16'd0);
  endtask

  initial begin
    idle_inputs();
    ma_exp  = 16'd0;
    mb_exp  = 16'd0;
    err_exp = 1'b0;
    #2;
    reset_dut();

    load_bytes(32'h56781234, 4, 0, 0);
    respond(84, 16'hBEEF, 0, 0, 1'b0);

    load_bytes(32'h56781234, 4, 0, 0);
    respond(84, 16'hBEEF, 5, 5, 1'b0);

    load_bytes(32'h56781234, 4, 0, 0);
    timeout_run();
    load_bytes(32'($urandom), 4, 30, 20);
    respond(20, 16'h0F1E, 1, 0, 1'b0);

    load_bytes(32'h44332211, 3, 0, 0);
    reset_dut();
    load_bytes(32'hDDCCBBAA, 4, 0, 0);
    respond(10, 16'($urandom), 0, 1, 1'b0);

    load_bytes(32'($urandom), 4, 50, 30);
    respond(T, 16'($urandom), 1, 0, 1'b0);

    load_bytes(32'($urandom), 4, 50, 30);
    respond(1, 16'($urandom), 0, 2, 1'b0);

    load_bytes(32'($urandom), 4, 0, 0);
    tick();
    tick();
    tick();
    reset_dut();

    load_bytes(32'($urandom), 4, 0, 0);
    respond(5, 16'hA5C3, 0, 0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      load_bytes(32'($urandom), 4, int'($urandom_range(60)), int'($urandom_range(30)));
      if ($urandom_range(99) < 15) timeout_run();
      else respond(int'($urandom_range(T, 1)), 16'($urandom),
                   int'($urandom_range(3)), int'($urandom_range(3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule

// File: doc/matrix_io_sequencer.md
MATRIX_IO_SEQUENCER -- requirements
Module: matrix_io_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 127: maximum cycles spent waiting for listo before abort; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 data_in  input  8  inbound byte stream carrying operand matrices.
REQ-005 data_valid  input  1  data_in holds a valid byte.
REQ-006 data_ready  output  1  sequencer accepts a byte this cycle.
REQ-007 matrixA  output  16  operand A to the downstream multiply unit.
REQ-008 matrixB  output  16  operand B to the downstream multiply unit.
REQ-009 enable  output  1  one-cycle start pulse to the multiply unit.
REQ-010 listo  input  1  multiply-unit completion pulse; result valid in the same cycle.
REQ-011 result  input  16  multiply-unit product matrix.
REQ-012 data_out  output  8  outbound result byte.
REQ-013 out_valid  output  1  data_out holds a valid byte.
REQ-014 out_ready  input  1  consumer accepts data_out this cycle.
REQ-015 busy  output  1  high in every state except LOAD.
REQ-016 err  output  1  sticky timeout flag.

Function
REQ-017 State machine states SHALL be LOAD, START, WAIT, SEND; all outputs registered.
REQ-018 Byte transfer in SHALL occur on a rising edge where data_valid and data_ready are both 1; data_ready SHALL be 1 only in LOAD.
REQ-019 In LOAD, a 2-bit byte counter SHALL route accepted bytes in order: 0 -> matrixA[7:0], 1 -> matrixA[15:8], 2 -> matrixB[7:0], 3 -> matrixB[15:8], then increment.
REQ-020 Acceptance of byte 3 SHALL clear the counter and move to START; enable SHALL be 1 for exactly the following cycle.
REQ-021 START SHALL unconditionally go to WAIT after one cycle and clear the timeout counter.
REQ-022 matrixA and matrixB SHALL stay constant from START until the next byte is accepted in LOAD.
REQ-023 In WAIT, listo=1 SHALL capture result into an internal 16-bit register and move to SEND with a 1-bit byte index cleared.
REQ-024 In WAIT without listo, the timeout counter SHALL increment each cycle; at count TIMEOUT_CYCLES-1 the next edge SHALL set err=1 and return to LOAD with no output bytes.
REQ-025 If listo and timeout coincide in the same cycle, listo SHALL win (capture, go to SEND, err unchanged).
REQ-026 listo in LOAD, START or SEND SHALL be ignored.
REQ-027 In SEND, out_valid SHALL be 1; data_out SHALL be captured[7:0] for index 0 and captured[15:8] for index 1.
REQ-028 data_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 Transfer out SHALL occur on an edge with out_valid and out_ready both 1; index 0 SHALL advance to 1; index 1 SHALL return to LOAD with out_valid=0 next cycle.
REQ-030 err SHALL clear when byte 0 of the next operand set is accepted.
REQ-031 enable SHALL never be asserted outside the single START cycle.

Reset
REQ-032 rst=1 SHALL immediately force: state LOAD, byte counter 0, timeout counter 0, matrixA=0, matrixB=0, captured result=0, enable=0, data_out=0, out_valid=0, busy=0, err=0; data_ready=1 from first edge after deassertion.
REQ-033 Reset mid-load, mid-WAIT or mid-SEND SHALL discard all partial operands and pending output bytes.

Verification
REQ-034 Bytes 34,12,78,56 with data_valid=1 on consecutive cycles -> matrixA=16'h1234, matrixB=16'h5678, enable high exactly one cycle, busy=1.
REQ-035 Stub multiply unit pulses listo with result=16'hBEEF 84 cycles after enable, out_ready=1 -> data_out EF then BE on consecutive cycles, then data_ready=1, err=0.
REQ-036 Same as REQ-035 with out_ready low for 5 cycles on each byte -> data_out and out_valid held stable, no byte lost or duplicated.
REQ-037 Stub never asserts listo, TIMEOUT_CYCLES=127 -> err=1 after 127 WAIT cycles, no out_valid, data_ready=1; next byte 0 accepted -> err=0.
REQ-038 rst pulsed after byte 2 accepted, then bytes AA,BB,CC,DD -> matrixA=16'hBBAA, matrixB=16'hDDCC; earlier bytes absent.
REQ-039 data_valid toggling 1/0 with gaps, stray listo pulses during LOAD -> bytes assembled in order, no enable until byte 3, stray listo ignored.
